// File: rtl/multi_read_port_ram_if.sv
// ---------------------------------------------------------------------------
// multi_read_port_ram_if
//
// Purpose : groups the write port, the read ports and the ready flag of
//           multi_read_port_ram into one bundle.
//
// Signals :
//   ready     slave -> master  high once the post-reset clear sweep is done
//   wEnable   master -> slave  write request
//   wAddr     master -> slave  write address (modulo ENTRY_NUM)
//   wStrobe   master -> slave  byte enables, bit i covers wData[8i+7:8i]
//   wData     master -> slave  write data
//   rEnable   master -> slave  per-port read request
//   rAddr     master -> slave  per-port read address (modulo ENTRY_NUM)
//   rData     slave -> master  per-port read data, held while not re-read
//   rValid    slave -> master  per-port read-data valid
//
// Handshake: there is no back-pressure. While ready=1 every request is
// accepted on the clock edge where it is seen; a read issued in cycle N
// returns rData[p] with rValid[p]=1 in cycle N+1. While ready=0 requests are
// dropped and rValid stays 0.
// ---------------------------------------------------------------------------
interface multi_read_port_ram_if #(
    parameter int ENTRY_NUM      = 1024,
    parameter int ENTRY_BIT_SIZE = 32,
    parameter int READ_PORT_NUM  = 2
) ();
    localparam int AW = $clog2(ENTRY_NUM);
    localparam int SW = ENTRY_BIT_SIZE / 8;

    logic                                           ready;
    logic                                           wEnable;
    logic [AW-1:0]                                  wAddr;
    logic [SW-1:0]                                  wStrobe;
    logic [ENTRY_BIT_SIZE-1:0]                      wData;
    logic [READ_PORT_NUM-1:0]                       rEnable;
    logic [READ_PORT_NUM-1:0][AW-1:0]               rAddr;
    logic [READ_PORT_NUM-1:0][ENTRY_BIT_SIZE-1:0]   rData;
    logic [READ_PORT_NUM-1:0]                       rValid;

    modport master (
        input  ready, rData, rValid,
        output wEnable, wAddr, wStrobe, wData, rEnable, rAddr
    );

    modport slave (
        output ready, rData, rValid,
        input  wEnable, wAddr, wStrobe, wData, rEnable, rAddr
    );
endinterface

// File: rtl/multi_read_port_ram.sv
// ---------------------------------------------------------------------------
// multi_read_port_ram
//
// Purpose : byte-strobed RAM with one write port and READ_PORT_NUM
//           independent registered read ports. After reset an internal sweep
//           writes zero to every entry (one per cycle) before the RAM reports
//           ready; requests arriving during the sweep are ignored.
//
// Ports   :
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          multi_read_port_ram_if.slave (write port, read ports, ready)
//   dbg_state_o  current FSM state, 1 = READY, 0 = INIT (sweep running)
//
// Configuration macro:
//   RAM_WRITE_BYPASS_EN  when defined, a read that hits the address written
//                        in the same cycle returns the strobed bytes of wData
//                        merged with the old entry. When undefined the read
//                        returns the old entry (read-first) and no forwarding
//                        logic exists.
// ---------------------------------------------------------------------------
module multi_read_port_ram #(
    parameter int ENTRY_NUM      = 1024,
    parameter int ENTRY_BIT_SIZE = 32,
    parameter int READ_PORT_NUM  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_read_port_ram_if.slave     bus,
    output logic                     dbg_state_o
);
    localparam int AW = $clog2(ENTRY_NUM);
    localparam int SW = ENTRY_BIT_SIZE / 8;
    localparam int W  = ENTRY_BIT_SIZE;
    localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRY_NUM - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [AW-1:0]                 sweep_q, sweep_d;

    // Storage array: deliberately without reset, it is cleared by the sweep.
    logic [W-1:0]                  mem_q [ENTRY_NUM];

    logic                          mem_we;
    logic [AW-1:0]                 mem_addr;
    logic [SW-1:0]                 mem_strb;
    logic [W-1:0]                  mem_wdata;
    logic [W-1:0]                  mem_mask;

    logic [READ_PORT_NUM-1:0][W-1:0] rdata_q, rdata_d;
    logic [READ_PORT_NUM-1:0]        rvalid_q, rvalid_d;

    // -----------------------------------------------------------------------
    // FSM next state and write-port selection. During INIT the sweep owns
    // the write port; the external write port is only used in READY.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        mem_we    = 1'b0;
        mem_addr  = bus.wAddr;
        mem_strb  = bus.wStrobe;
        mem_wdata = bus.wData;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = sweep_q;
                mem_strb  = '1;
                mem_wdata = '0;
                sweep_d   = sweep_q + AW'(1);
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = bus.wEnable;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Byte strobes expanded to a bit mask.
    always_comb begin
        mem_mask = '0;
        for (int b = 0; b < SW; b++) begin
            mem_mask[8*b +: 8] = {8{mem_strb[b]}};
        end
    end

    // -----------------------------------------------------------------------
    // Read ports. rData holds its previous value when the port is idle.
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = '0;
        for (int p = 0; p < READ_PORT_NUM; p++) begin
            if (state_q == ST_READY && bus.rEnable[p]) begin
                rvalid_d[p] = 1'b1;
                rdata_d[p]  = mem_q[bus.rAddr[p]];
`ifdef RAM_WRITE_BYPASS_EN
                // Same-cycle hit on the write address: forward the new bytes.
                if (bus.wEnable && (bus.rAddr[p] == bus.wAddr)) begin
                    rdata_d[p] = (mem_q[bus.rAddr[p]] & ~mem_mask) |
                                 (bus.wData & mem_mask);
                end
`endif
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            sweep_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
        end
    end

    assign bus.ready   = (state_q == ST_READY);
    assign bus.rData   = rdata_q;
    assign bus.rValid  = rvalid_q;
    assign dbg_state_o = (state_q == ST_READY);

endmodule

// File: doc/multi_read_port_ram.md
MULTI_READ_PORT_RAM -- requirements
Module: multi_read_port_ram

Interface
REQ-001 Parameter ENTRY_NUM, default 1024, number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter ENTRY_BIT_SIZE, default 32, entry width; SHALL be a multiple of 8.
REQ-003 Parameter READ_PORT_NUM, default 2, number of independent read ports, 1..4.
REQ-004 clk  input  1  the single clock; all logic SHALL be rising-edge clocked.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ready  output  1  high once the post-reset clear sweep has completed.
REQ-007 wEnable  input  1  write request.
REQ-008 wAddr  input  $clog2(ENTRY_NUM)  write address.
REQ-009 wStrobe  input  ENTRY_BIT_SIZE/8  byte enables; bit i covers wData[8i+7:8i].
REQ-010 wData  input  ENTRY_BIT_SIZE  write data.
REQ-011 rEnable  input  READ_PORT_NUM  per-port read request.
REQ-012 rAddr  input  READ_PORT_NUM x $clog2(ENTRY_NUM)  per-port read address.
REQ-013 rData  output  READ_PORT_NUM x ENTRY_BIT_SIZE  per-port read data.
REQ-014 rValid  output  READ_PORT_NUM  per-port read-data valid.

Function
REQ-015 Two states: INIT and READY; INIT SHALL be entered on reset.
REQ-016 INIT: an internal counter SHALL sweep addresses 0..ENTRY_NUM-1, one per cycle, writing all-zero data with every byte enabled.
REQ-017 After the counter writes ENTRY_NUM-1, the block SHALL go to READY on the next edge; ready SHALL be high from that edge (ENTRY_NUM cycles after reset release).
REQ-018 In INIT, wEnable and rEnable SHALL be ignored; rValid SHALL stay 0.
REQ-019 READY: on wEnable=1, only bytes with wStrobe=1 SHALL be updated at wAddr; wEnable=1 with wStrobe=0 SHALL leave contents unchanged.
REQ-020 READY: on rEnable[p]=1, rData[p] SHALL present the entry at rAddr[p] exactly one cycle later, with rValid[p]=1 in that cycle.
REQ-021 rEnable[p]=0 SHALL drive rValid[p]=0 next cycle; rData[p] SHALL hold its last value.
REQ-022 Ports SHALL operate independently; several ports reading the same address in one cycle SHALL all return the same data.
REQ-023 Read/write address collision behaviour SHALL be fixed by REQ-029/REQ-030.
REQ-024 A write SHALL be visible to any read issued in a later cycle.
REQ-025 Addresses SHALL be used modulo ENTRY_NUM; no out-of-range check.

Reset
REQ-026 Reset assertion SHALL immediately force ready=0, rValid=0, rData=0, sweep counter=0, state INIT.
REQ-027 Reset asserted mid-sweep or mid-operation SHALL abort it; array contents are undefined until the new sweep finishes.
REQ-028 The array itself SHALL NOT be reset directly; clearing SHALL occur only through the sweep.

Configuration
REQ-029 With RAM_WRITE_BYPASS_EN defined: when wEnable=1 and rEnable[p]=1 with rAddr[p]=wAddr in one READY cycle, rData[p] SHALL return strobed bytes from wData and unstrobed bytes from the old entry.
REQ-030 Without RAM_WRITE_BYPASS_EN: the same collision SHALL return the old entry (read-first); no forwarding logic SHALL be instantiated.

Verification (ENTRY_NUM=16, ENTRY_BIT_SIZE=32, READ_PORT_NUM=2)
REQ-031 Reset release, no stimulus -> ready rises after exactly 16 cycles; reads of all 16 addresses return 0x00000000.
REQ-032 Write addr 3 data 0xDEADBEEF strobe 0xF, next cycle write addr 3 data 0x11223344 strobe 0x5, then read port 0 addr 3 -> 0xDE22BE44, rValid[0]=1 one cycle after rEnable.
REQ-033 Addr 5 = 0xAAAAAAAA; same cycle write addr 5 0x12345678 strobe 0x3 and read both ports addr 5 -> bypass build 0xAAAA5678 on both; non-bypass build 0xAAAAAAAA.
REQ-034 During INIT, write addr 7 0xFFFFFFFF and read port 1 -> rValid[1]=0; after ready, addr 7 reads 0x00000000.
REQ-035 Reset asserted at sweep cycle 8 after addr 2 was written 0x5 -> outputs 0 immediately; after release ready rises 16 cycles later, addr 2 reads 0x00000000.
REQ-036 Port 0 reads addr 1 while port 1 reads addr 2 every cycle for 10 cycles -> both rValid continuously 1 with correct independent data.
